// File: rtl/sd_cmd_pkg.sv
// sd_cmd_pkg: state encodings, frame lengths and CRC7 constants for the CMD response receiver
package sd_cmd_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_START, RECEIVE, DONE, TIMEOUT} state_t;
  localparam int SHORT_LEN = 48;
  localparam int LONG_LEN = 136;
  localparam logic [6:0] CRC7_POLY = 7'h09;
  localparam int NCR_TIMEOUT_DEF = 64;
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic d);
    return {crc[5:0], 1'b0} ^ ((crc[6] ^ d) ? CRC7_POLY : 7'h00);
  endfunction
endpackage

// File: rtl/cmd_response_receiver_if.sv
// cmd_response_receiver_if: receive request, serial CMD line and response result signals
interface cmd_response_receiver_if;
  logic enable;
  logic long_response;
  logic cmd_in;
  logic [sd_cmd_pkg::LONG_LEN-1:0] pad_response;
  logic reception_complete;
  logic no_response;
  logic crc_error;
  modport master(output enable, long_response, cmd_in, input pad_response, reception_complete, no_response, crc_error);
  modport slave(input enable, long_response, cmd_in, output pad_response, reception_complete, no_response, crc_error);
endinterface

// File: rtl/cmd_crc7.sv
// cmd_crc7: serial CRC7 (x^7+x^3+1, seed 0) register with clear and enable
module cmd_crc7
  import sd_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic       enable,
  input  logic       data_in,
  output logic [6:0] crc
);
  logic [6:0] crc_q, crc_d;
  always_comb crc_d = clear ? 7'h00 : enable ? crc7_step(crc_q, data_in) : crc_q;
  always_ff @(posedge clk) crc_q <= crc_d;
  assign crc = crc_q;
endmodule

// File: rtl/cmd_response_receiver.sv
// cmd_response_receiver: captures an SD CMD response frame, flags timeout, CRC7 and end-bit errors
module cmd_response_receiver
  import sd_cmd_pkg::*;
#(
  parameter int NCR_TIMEOUT = NCR_TIMEOUT_DEF
) (
  input logic sd_clock,
  input logic reset,
  cmd_response_receiver_if.slave bus
);
  localparam int CW = $clog2((NCR_TIMEOUT > LONG_LEN ? NCR_TIMEOUT : LONG_LEN) + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, bit_q, bit_d, len_q, len_d;
  logic [LONG_LEN-1:0] pad_q, pad_d, pad_sh;
  logic sample, crc_clr, crc_en;
  logic [6:0] crc;
  assign pad_sh = {pad_q[LONG_LEN-2:0], bus.cmd_in};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    len_d = len_q;
    pad_d = pad_q;
    crc_clr = 1'b0;
    sample = 1'b0;
    if (!bus.enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_START;
          len_d = bus.long_response ? CW'(LONG_LEN) : CW'(SHORT_LEN);
          cnt_d = '0;
          bit_d = '0;
          pad_d = '0;
          crc_clr = 1'b1;
        end
        WAIT_START: begin
          // a start bit on the last timeout cycle wins over the timeout
          sample = !bus.cmd_in;
          bit_d = sample ? CW'(1) : bit_q;
          cnt_d = sample ? cnt_q : cnt_q + CW'(1);
          pad_d = sample ? pad_sh : pad_q;
          state_d = sample ? RECEIVE : cnt_q == CW'(NCR_TIMEOUT - 1) ? TIMEOUT : WAIT_START;
        end
        RECEIVE: begin
          sample = 1'b1;
          bit_d = bit_q + CW'(1);
          pad_d = pad_sh;
          state_d = bit_d == len_q ? DONE : RECEIVE;
        end
        default: ;
      endcase
    end
  end
  // CRC window: frame bits len-1-skip .. 8, where long frames skip their 8-bit header
  assign crc_en = sample && bit_d <= len_q - CW'(8) && bit_d > (len_q == CW'(LONG_LEN) ? CW'(8) : CW'(0));
  cmd_crc7 u_crc (
    .clk(sd_clock),
    .clear(reset | crc_clr),
    .enable(crc_en),
    .data_in(bus.cmd_in),
    .crc(crc)
  );
  always_ff @(posedge sd_clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      len_q <= '0;
      pad_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      len_q <= len_d;
      pad_q <= pad_d;
    end
  end
  assign bus.pad_response = pad_q;
  assign bus.reception_complete = state_q == DONE;
  assign bus.no_response = state_q == TIMEOUT;
  assign bus.crc_error = state_q == DONE && (crc != pad_q[7:1] || !pad_q[0]);
endmodule

// File: tb/tb_cmd_response_receiver.sv
// tb_cmd_response_receiver: directed self-checking bench for cmd_response_receiver
module tb_cmd_response_receiver;
  logic sd_clock = 1'b0;
  logic reset = 1'b1;
  int compared = 0;
  int mismatched = 0;
  logic [135:0] sf, bf, lf, lbad;
  cmd_response_receiver_if bus();
  cmd_response_receiver #(.NCR_TIMEOUT(64)) dut (
    .sd_clock(sd_clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 sd_clock = ~sd_clock;
  task automatic tick();
    @(posedge sd_clock);
    #1;
  endtask
  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] want);
    compared++;
    assert (obs === want) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask
  task automatic flags(input string tag, input logic rc, input logic nr, input logic ce);
    check({tag, "_complete"}, bus.reception_complete, rc);
    check({tag, "_no_resp"}, bus.no_response, nr);
    check({tag, "_crc_err"}, bus.crc_error, ce);
  endtask
  task automatic shift(input logic [135:0] f, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      bus.cmd_in = f[i];
      tick();
    end
    bus.cmd_in = 1'b1;
  endtask
  task automatic rx_frame(input string tag, input logic [135:0] f, input int n, input logic err);
    shift(f, n - 1, n - 1);
    check({tag, "_no_resp_after_start"}, bus.no_response, 1'b0);
    shift(f, n - 2, 1);
    check({tag, "_early_complete"}, bus.reception_complete, 1'b0);
    shift(f, 0, 0);
    flags(tag, 1'b1, 1'b0, err);
    check({tag, "_pad"}, bus.pad_response, f);
  endtask
  function automatic logic [6:0] crc7(input logic [135:0] v, input int hi, input int lo);
    logic [6:0] c = 7'h00;
    for (int i = hi; i >= lo; i--) c = {c[5:0], 1'b0} ^ ((c[6] ^ v[i]) ? 7'h09 : 7'h00);
    return c;
  endfunction
  initial begin
    bus.enable = 1'b0;
    bus.long_response = 1'b0;
    bus.cmd_in = 1'b1;
    sf = 136'h110000090067;
    bf = 136'h11000009006F;
    lf = {8'h3F, 64'h0123456789ABCDEF, 56'hFEDCBA98765432, 8'h01};
    lf[7:1] = crc7(lf, 127, 8);
    lbad = lf;
    lbad[60] = ~lbad[60];
    tick();
    tick();
    flags("reset", 1'b0, 1'b0, 1'b0);
    check("reset_pad", bus.pad_response, 136'h0);
    reset = 1'b0;
    bus.enable = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    rx_frame("short", sf, 48, 1'b0);
    tick();
    flags("short_hold", 1'b1, 1'b0, 1'b0);
    bus.enable = 1'b0;
    tick();
    flags("short_drop", 1'b0, 1'b0, 1'b0);
    check("short_pad_kept", bus.pad_response, sf);
    bus.enable = 1'b1;
    tick();
    check("pad_cleared", bus.pad_response, 136'h0);
    rx_frame("bad_crc", bf, 48, 1'b1);
    bus.enable = 1'b0;
    tick();
    bus.enable = 1'b1;
    tick();
    for (int i = 0; i < 63; i++) tick();
    check("timeout_early", bus.no_response, 1'b0);
    tick();
    flags("timeout", 1'b0, 1'b1, 1'b0);
    check("timeout_pad", bus.pad_response, 136'h0);
    for (int i = 0; i < 3; i++) tick();
    check("timeout_hold", bus.no_response, 1'b1);
    bus.enable = 1'b0;
    tick();
    flags("timeout_drop", 1'b0, 1'b0, 1'b0);
    bus.enable = 1'b1;
    tick();
    for (int i = 0; i < 63; i++) tick();
    rx_frame("late_start", sf, 48, 1'b0);
    bus.enable = 1'b0;
    tick();
    bus.long_response = 1'b1;
    bus.enable = 1'b1;
    tick();
    bus.long_response = 1'b0;
    rx_frame("long", lf, 136, 1'b0);
    bus.enable = 1'b0;
    tick();
    bus.long_response = 1'b1;
    bus.enable = 1'b1;
    tick();
    bus.long_response = 1'b0;
    rx_frame("long_bad", lbad, 136, 1'b1);
    bus.enable = 1'b0;
    tick();
    bus.enable = 1'b1;
    tick();
    shift(sf, 47, 28);
    reset = 1'b1;
    tick();
    flags("mid_reset", 1'b0, 1'b0, 1'b0);
    check("mid_reset_pad", bus.pad_response, 136'h0);
    tick();
    flags("mid_reset_hold", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    bus.enable = 1'b0;
    tick();
    bus.enable = 1'b1;
    tick();
    shift(sf, 47, 28);
    bus.enable = 1'b0;
    tick();
    flags("mid_drop", 1'b0, 1'b0, 1'b0);
    check("mid_drop_pad", bus.pad_response, 136'h11000);
    bus.enable = 1'b1;
    tick();
    check("restart_pad", bus.pad_response, 136'h0);
    rx_frame("restart", sf, 48, 1'b0);
    bus.enable = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
